// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared types and helpers for the PS/2 scancode decoder.
//   ps2_state_t   : prefix-tracking FSM states
//   PS2_EXT/BRK   : extended (E0) and break (F0) prefix bytes
//   key_event_t   : {extended, released, code} event word (10 bits)
//   ps2_frame_ok  : start/stop/odd-parity check of an 11-bit frame
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } key_event_t;

    // Frame layout: [10] start, [9:2] d0..d7, [1] parity, [0] stop.
    // Odd parity means data bits plus parity bit contain an odd number of ones.
    function automatic logic ps2_frame_ok(input logic [10:0] frame);
        return (frame[10] == 1'b0) && (frame[0] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
// Synchronous fall-through FIFO for decoded key events.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data this cycle (ignored when full unless popping)
//   push_data  : event word to store
//   pop        : remove head this cycle (ignored when empty)
//   rd_data    : current head (zero while empty)
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A pop frees the slot the push needs, so a full FIFO still accepts
    // a write in the same cycle as a read.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is held in registers; gate to zero so an empty FIFO shows no stale data.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage has no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns strobed 11-bit PS/2 frames into {extended, released, code} key events.
//   clk, reset   : clock, synchronous active-high reset
//   frame_in     : captured frame ([10] start, [9:2] d0..d7, [1] parity, [0] stop)
//   frame_strobe : one-cycle pulse, frame_in is valid this cycle
//   ev_valid     : event FIFO head is valid
//   ev_data      : head event {extended, released, code[7:0]}
//   ev_ready     : consumer takes the head this cycle
//   frame_error  : pulse, bad start/stop/parity
//   seq_error    : pulse, illegal prefix sequence
//   overflow     : pulse, event dropped because the FIFO was full
//   ev_count     : FIFO occupancy
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [10:0]                   frame_in,
    input  logic                          frame_strobe,
    output logic                          ev_valid,
    output logic [9:0]                    ev_data,
    input  logic                          ev_ready,
    output logic                          frame_error,
    output logic                          seq_error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count
);

    ps2_state_t state_reg;
    ps2_state_t state_next;
    logic       frame_error_reg;
    logic       frame_error_next;
    logic       seq_error_reg;
    logic       seq_error_next;
    logic       overflow_reg;
    logic       overflow_next;

    logic [7:0] code;
    logic       frame_ok;
    logic       is_ext;
    logic       is_brk;
    logic       emit;
    key_event_t ev_next;
    logic       fifo_full;
    logic       fifo_empty;
    logic [9:0] fifo_head;

    // d0 arrives first and sits at frame bit 9; reverse into code[7:0].
    for (genvar gi = 0; gi < 8; gi++) begin : g_code
        assign code[gi] = frame_in[9-gi];
    end

    assign frame_ok = ps2_frame_ok(frame_in);
    assign is_ext   = (code == PS2_EXT);
    assign is_brk   = (code == PS2_BRK);

    always_comb begin
        state_next       = state_reg;
        emit             = 1'b0;
        ev_next.extended = 1'b0;
        ev_next.released = 1'b0;
        ev_next.code     = code;
        frame_error_next = 1'b0;
        seq_error_next   = 1'b0;
        if (frame_strobe) begin
            if (!frame_ok) begin
                // A corrupted byte may have been part of a prefix; start over.
                frame_error_next = 1'b1;
                state_next       = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (is_ext) begin
                            state_next = GOT_E0;
                        end else if (is_brk) begin
                            state_next = GOT_F0;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    GOT_E0: begin
                        if (is_brk) begin
                            state_next = GOT_E0F0;
                        end else if (is_ext) begin
                            // Repeated E0 is flagged but the extended prefix is kept.
                            seq_error_next = 1'b1;
                        end else begin
                            emit             = 1'b1;
                            ev_next.extended = 1'b1;
                            state_next       = IDLE;
                        end
                    end
                    GOT_F0: begin
                        state_next = IDLE;
                        if (is_ext || is_brk) begin
                            seq_error_next = 1'b1;
                        end else begin
                            emit             = 1'b1;
                            ev_next.released = 1'b1;
                        end
                    end
                    default: begin // GOT_E0F0
                        state_next = IDLE;
                        if (is_ext || is_brk) begin
                            seq_error_next = 1'b1;
                        end else begin
                            emit             = 1'b1;
                            ev_next.extended = 1'b1;
                            ev_next.released = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Dropped only when full and the consumer is not freeing a slot this cycle.
    assign overflow_next = emit && fifo_full && !ev_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            frame_error_reg <= 1'b0;
            seq_error_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frame_error_reg <= frame_error_next;
            seq_error_reg   <= seq_error_next;
            overflow_reg    <= overflow_next;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emit),
        .push_data (ev_next),
        .pop       (ev_ready),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (ev_count)
    );

    assign ev_valid    = !fifo_empty;
    assign ev_data     = fifo_head;
    assign frame_error = frame_error_reg;
    assign seq_error   = seq_error_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

    logic        clk;
    logic        reset;
    logic [10:0] frame_in;
    logic        frame_strobe;
    logic        ev_valid;
    logic [9:0]  ev_data;
    logic        ev_ready;
    logic        frame_error;
    logic        seq_error;
    logic        overflow;
    logic [2:0]  ev_count;

    int total = 0;
    int bad   = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_in     (frame_in),
        .frame_strobe (frame_strobe),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .ev_ready     (ev_ready),
        .frame_error  (frame_error),
        .seq_error    (seq_error),
        .overflow     (overflow),
        .ev_count     (ev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a well-formed frame for a byte: start 0, d0..d7 at bits 9..2, odd parity, stop 1.
    function automatic logic [10:0] mk(input logic [7:0] c);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9-i] = c[i];
        f[1] = ~^c;
        f[0] = 1'b1;
        return f;
    endfunction

    // Called at a negedge; returns at the next negedge where the results are visible.
    task automatic strobe(input logic [10:0] f);
        frame_in     = f;
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        $display("strobe frame=%h -> valid=%0b data=%h count=%0d ferr=%0b serr=%0b ovf=%0b",
                 f, ev_valid, ev_data, ev_count, frame_error, seq_error, overflow);
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        $display("pop -> valid=%0b data=%h count=%0d", ev_valid, ev_data, ev_count);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++;
        if (ev_valid !== 1'b0 || ev_data !== 10'h000 || ev_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_fifo: valid=%0b data=%h count=%0d required 0/000/0", ev_valid, ev_data, ev_count);
        end
        total++;
        if ({frame_error, seq_error, overflow} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses: got %b required 000", {frame_error, seq_error, overflow});
        end
    endtask

    task automatic test_make();
        strobe(11'h0E1);
        total++;
        if (ev_valid !== 1'b1 || ev_data !== 10'h01C || ev_count !== 3'd1) begin
            bad++;
            $display("FAIL make: valid=%0b data=%h count=%0d required 1/01C/1", ev_valid, ev_data, ev_count);
        end
        pop();
        total++;
        if (ev_valid !== 1'b0 || ev_count !== 3'd0) begin
            bad++;
            $display("FAIL make_pop: valid=%0b count=%0d required 0/0", ev_valid, ev_count);
        end
        // Ready while empty must not disturb the count.
        pop();
        total++;
        if (ev_valid !== 1'b0 || ev_count !== 3'd0) begin
            bad++;
            $display("FAIL pop_empty: valid=%0b count=%0d required 0/0", ev_valid, ev_count);
        end
    endtask

    task automatic test_break();
        strobe(11'h03F);
        total++;
        if (ev_valid !== 1'b0 || ev_count !== 3'd0) begin
            bad++;
            $display("FAIL break_prefix: valid=%0b count=%0d required 0/0", ev_valid, ev_count);
        end
        strobe(11'h0E1);
        total++;
        if (ev_valid !== 1'b1 || ev_data !== 10'h11C || ev_count !== 3'd1) begin
            bad++;
            $display("FAIL break: valid=%0b data=%h count=%0d required 1/11C/1", ev_valid, ev_data, ev_count);
        end
        pop();
    endtask

    task automatic test_ext_break();
        strobe(11'h01D);
        strobe(11'h03F);
        strobe(11'h0E1);
        total++;
        if (ev_valid !== 1'b1 || ev_data !== 10'h31C || ev_count !== 3'd1 || seq_error !== 1'b0) begin
            bad++;
            $display("FAIL ext_break: valid=%0b data=%h count=%0d serr=%0b required 1/31C/1/0",
                     ev_valid, ev_data, ev_count, seq_error);
        end
        pop();
        strobe(11'h01D);
        total++;
        if (seq_error !== 1'b0) begin
            bad++;
            $display("FAIL seq_first_e0: seq_error=%0b required 0", seq_error);
        end
        strobe(11'h01D);
        total++;
        if (seq_error !== 1'b1 || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL seq_double_e0: seq_error=%0b valid=%0b required 1/0", seq_error, ev_valid);
        end
        // Still in GOT_E0: next ordinary byte is extended make.
        strobe(11'h0E1);
        total++;
        if (seq_error !== 1'b0 || ev_data !== 10'h21C || ev_count !== 3'd1) begin
            bad++;
            $display("FAIL seq_stay_e0: serr=%0b data=%h count=%0d required 0/21C/1", seq_error, ev_data, ev_count);
        end
        pop();
        // F0 then E0 is illegal and returns to IDLE.
        strobe(11'h03F);
        strobe(11'h01D);
        total++;
        if (seq_error !== 1'b1) begin
            bad++;
            $display("FAIL seq_f0_e0: seq_error=%0b required 1", seq_error);
        end
        strobe(11'h0E1);
        total++;
        if (ev_data !== 10'h01C || ev_count !== 3'd1) begin
            bad++;
            $display("FAIL seq_f0_e0_idle: data=%h count=%0d required 01C/1", ev_data, ev_count);
        end
        pop();
    endtask

    task automatic test_frame_error();
        strobe(11'h0E3);
        total++;
        if (frame_error !== 1'b1 || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_parity: frame_error=%0b valid=%0b required 1/0", frame_error, ev_valid);
        end
        strobe(11'h4E1);
        total++;
        if (frame_error !== 1'b1 || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_start: frame_error=%0b valid=%0b required 1/0", frame_error, ev_valid);
        end
        strobe(11'h0E0);
        total++;
        if (frame_error !== 1'b1 || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_stop: frame_error=%0b valid=%0b required 1/0", frame_error, ev_valid);
        end
        @(negedge clk);
        total++;
        if (frame_error !== 1'b0) begin
            bad++;
            $display("FAIL frame_error_pulse: frame_error=%0b required 0", frame_error);
        end
        strobe(11'h01D);
        strobe(11'h0E3);
        strobe(11'h0E1);
        total++;
        if (frame_error !== 1'b0 || ev_data !== 10'h01C || ev_count !== 3'd1) begin
            bad++;
            $display("FAIL prefix_cleared: ferr=%0b data=%h count=%0d required 0/01C/1", frame_error, ev_data, ev_count);
        end
        pop();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33; codes[3] = 8'h44; codes[4] = 8'h55;
        for (int i = 0; i < 5; i++) strobe(11'h0E1);
        total++;
        if (ev_count !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow: count=%0d overflow=%0b required 4/1", ev_count, overflow);
        end
        repeat (2) @(negedge clk);
        total++;
        if (overflow !== 1'b0 || ev_data !== 10'h01C || ev_valid !== 1'b1) begin
            bad++;
            $display("FAIL overflow_hold: ovf=%0b data=%h valid=%0b required 0/01C/1", overflow, ev_data, ev_valid);
        end
        for (int i = 0; i < 4; i++) pop();
        total++;
        if (ev_count !== 3'd0 || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL overflow_drain: count=%0d valid=%0b required 0/0", ev_count, ev_valid);
        end
        // Fill with distinct codes, then push a fifth while popping.
        for (int i = 0; i < 4; i++) strobe(mk(codes[i]));
        ev_ready = 1'b1;
        strobe(mk(codes[4]));
        ev_ready = 1'b0;
        total++;
        if (ev_count !== 3'd4 || overflow !== 1'b0 || ev_data !== {2'b00, codes[1]}) begin
            bad++;
            $display("FAIL full_push_pop: count=%0d ovf=%0b data=%h required 4/0/%h",
                     ev_count, overflow, ev_data, {2'b00, codes[1]});
        end
        for (int i = 1; i < 5; i++) begin
            total++;
            if (ev_valid !== 1'b1 || ev_data !== {2'b00, codes[i]}) begin
                bad++;
                $display("FAIL fifo_order[%0d]: valid=%0b data=%h required 1/%h", i, ev_valid, ev_data, {2'b00, codes[i]});
            end
            pop();
        end
        total++;
        if (ev_count !== 3'd0) begin
            bad++;
            $display("FAIL fifo_empty_end: count=%0d required 0", ev_count);
        end
    endtask

    task automatic test_reset_mid();
        strobe(11'h0E1);
        strobe(11'h01D);
        reset        = 1'b1;
        frame_in     = 11'h0E1;
        frame_strobe = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        frame_strobe = 1'b0;
        $display("reset with strobe -> valid=%0b data=%h count=%0d", ev_valid, ev_data, ev_count);
        total++;
        if (ev_valid !== 1'b0 || ev_data !== 10'h000 || ev_count !== 3'd0 ||
            {frame_error, seq_error, overflow} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid: valid=%0b data=%h count=%0d pulses=%b required all 0",
                     ev_valid, ev_data, ev_count, {frame_error, seq_error, overflow});
        end
        strobe(11'h0E1);
        total++;
        if (ev_data !== 10'h01C || ev_count !== 3'd1) begin
            bad++;
            $display("FAIL reset_mid_after: data=%h count=%0d required 01C/1", ev_data, ev_count);
        end
        pop();
    endtask

    initial begin
        reset        = 1'b1;
        frame_in     = 11'h000;
        frame_strobe = 1'b0;
        ev_ready     = 1'b0;
        @(negedge clk);
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_frame_error();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
